avalon_mem_sequencer: RTL and testbench
=======================================

# avalon_mem_sequencer

Sequences all CPU data and instruction-fetch accesses onto the Avalon memory-mapped master bus, replacing direct drive of address/read/write from the control FSM. Accepts one request at a time, registers it, holds bus signals stable across `waitrequest` stalls, and generates `byteenable` and write-lane replication from access size and address. On reads it extracts and sign/zero-extends the addressed lane. It provides the `stall` the multicycle state machine consumes.

## Interface
- `MAX_WAIT`, 0, max consecutive cycles `waitrequest` may be high before abort; 0 disables the watchdog
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req`  in  1  access request, sampled only in IDLE
- `we`  in  1  1 = write, 0 = read
- `addr`  in  32  byte address
- `size`  in  2  00 byte, 01 half, 10 word; 11 treated as word
- `sign_ext`  in  1  sign-extend byte/half reads (0 = zero-extend)
- `wdata`  in  32  store data, right-justified
- `stall`  out  1  high whenever state != IDLE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  high with `done` on misalign or timeout
- `rdata`  out  32  extended read data, held until next `done`
- `address`  out  32  `{addr_q[31:2],2'b00}`
- `read`, `write`  out  1  Avalon strobes
- `byteenable`  out  4  lane enables
- `writedata`  out  32  lane-replicated store data
- `waitrequest`  in  1  slave stall
- `readdata`  in  32  slave data

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: when `req`=1 at a rising edge, register `we`, `addr`, `size`, `sign_ext`, `wdata`.
  - Misaligned requests go to DONE with `err`=1 and issue no bus strobe. Misaligned means half with `addr[0]`=1, or word with `addr[1:0]`!=0.
  - Aligned requests go to ACCESS.
- ACCESS: `read`=~`we_q`, `write`=`we_q`.
  - `address`, `byteenable` and `writedata` are combinational from registered values only, so they are stable for the whole state.
  - Stay while `waitrequest`=1.
  - On an edge with `waitrequest`=0, go to DONE. For a read, capture the extended data into `rdata`.
- DONE: `done`=1 for exactly one cycle, then IDLE. `req` is ignored in DONE.
- Lane n = bits [8n+7:8n].
  - Byte: `byteenable` = 1<<`addr[1:0]`, `writedata` = {4{wdata[7:0]}}.
  - Half: `byteenable` = `addr[1]` ? 1100 : 0011, `writedata` = {2{wdata[15:0]}}.
  - Word: `byteenable` = 1111, `writedata` = `wdata`.
- Read extraction:
  - Byte lane `addr[1:0]` or half lane `addr[1]` is shifted to bits [7:0]/[15:0].
  - Upper bits are filled with the lane MSB if `sign_ext`, else 0.
  - Word reads pass through unchanged.
- Watchdog (`MAX_WAIT`>0):
  - An 8-bit-minimum counter clears on entry to ACCESS and increments each cycle `waitrequest`=1.
  - When it reaches `MAX_WAIT` with `waitrequest` still 1, drop strobes and go to DONE with `err`=1.
  - `rdata` is unchanged on any `err`.
- Outside ACCESS, `read`=`write`=0 and `byteenable`=0000. `address` and `writedata` still reflect the registered values.

## Timing
- Reset (asynchronous, immediate, including mid-ACCESS):
  - State IDLE; `read`=`write`=0, `stall`=`done`=`err`=0.
  - `rdata`=0, `byteenable`=0000, `address`=0, `writedata`=0.
  - The watchdog counter clears.
- Zero-wait access: `req` sampled at edge E0; strobe high during cycle E0–E1; `done` high during E1–E2; `stall` falls at E2. Total latency 2 cycles.
- Each `waitrequest` cycle adds exactly one cycle of latency.
- Misaligned request: `done`/`err` high during E0–E1, no strobe ever asserted.
- `stall` rises combinationally on entry to ACCESS/DONE. It is not high in the cycle `req` is presented.
- `req` held high across DONE→IDLE starts a new access at the first IDLE edge, giving back-to-back throughput of one access per 3 cycles at zero wait.
- `waitrequest` is ignored outside ACCESS.
- `readdata` is sampled only on the completing edge.

## Test plan
- Word read, addr 0x0000_1004, `waitrequest`=0, `readdata`=0xDEADBEEF -> `read` high 1 cycle, `address`=0x1004, `byteenable`=1111, `done` 2 cycles after `req`, `rdata`=0xDEADBEEF, `err`=0.
- Byte read signed, addr 0x2003, `readdata`=0x80FF_1234 -> `byteenable`=1000, `rdata`=0xFFFF_FF80. Same with `sign_ext`=0 -> 0x0000_0080.
- Half write, addr 0x3002, `wdata`=0x0000_ABCD, `waitrequest` high 3 cycles -> `write` and `address`=0x3000 stable for 4 cycles, `byteenable`=1100, `writedata`=0xABCD_ABCD, `done` 5 cycles after `req`.
- Word read at 0x4001 -> no `read`/`write` strobe, `done`=`err`=1 one cycle after `req`, `rdata` unchanged.
- `MAX_WAIT`=4, `waitrequest` stuck high -> strobe drops after 4 wait cycles, `done`=`err`=1, state returns to IDLE.
- `reset` asserted mid-ACCESS with `read`=1 -> `read`, `stall` and `rdata` go to 0 without a clock edge; after release, the next `req` completes normally.

Source files
------------

// File: rtl/avalon_mem_sequencer.sv
// Avalon-MM master sequencer for CPU data and instruction-fetch accesses.
// It takes one request at a time and registers it. Bus signals are driven
// only from the registered copy, so they stay stable while waitrequest is
// high. The block builds byteenable and store-lane replication from the
// access size and address, and extends read lanes into rdata. An optional
// watchdog aborts a stuck slave.
module avalon_mem_sequencer #(
  parameter int MAX_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  // The watchdog counter is at least 8 bits and grows if MAX_WAIT needs more.
  localparam int CW = (MAX_WAIT > 255) ? $clog2(MAX_WAIT + 1) : 8;
  // WD_LAST is the count already reached when the final permitted wait
  // cycle is being spent.
  localparam logic [CW-1:0] WD_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state, state_d;
  logic            err_q, err_d;
  logic [CW-1:0]   wd_cnt;
  logic            load, cap_rd, clr_cnt, inc_cnt;

  logic            we_q, sext_q;
  logic [31:0]     addr_q, wdata_q;
  logic [1:0]      size_q;

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return (a != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_enables(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Moves the addressed lane down to bit 0, then sign- or zero-fills above it.
  function automatic logic [31:0] extend(input logic [1:0] sz, input logic [1:0] a,
                                         input logic sx, input logic [31:0] rd);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [31:0] s;
    b = rd[{a, 3'b000} +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (sz)
      2'b00: begin
        s = 32'($signed(b));
        return sx ? s : {24'h0, b};
      end
      2'b01: begin
        s = 32'($signed(h));
        return sx ? s : {16'h0, h};
      end
      default: return rd;
    endcase
  endfunction

  // Control state, the latched error flag and the watchdog count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      err_q  <= 1'b0;
      wd_cnt <= '0;
    end else begin
      state <= state_d;
      err_q <= err_d;
      if (clr_cnt)
        wd_cnt <= '0;
      else if (inc_cnt)
        wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Next-state decode. A request is accepted only in IDLE. A completing or
  // aborting edge in ACCESS moves to DONE.
  always_comb begin
    state_d = state;
    err_d   = err_q;
    load    = 1'b0;
    cap_rd  = 1'b0;
    clr_cnt = 1'b0;
    inc_cnt = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          load = 1'b1;
          if (misaligned(size, addr[1:0])) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
            err_d   = 1'b0;
            clr_cnt = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (!waitrequest) begin
          state_d = DONE;
          err_d   = 1'b0;
          cap_rd  = ~we_q;
        end else if ((MAX_WAIT > 0) && (wd_cnt == WD_LAST)) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          inc_cnt = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered request fields, plus read data captured on the completing edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      if (load) begin
        we_q    <= we;
        sext_q  <= sign_ext;
        addr_q  <= addr;
        size_q  <= size;
        wdata_q <= wdata;
      end
      if (cap_rd)
        rdata <= extend(size_q, addr_q[1:0], sext_q, readdata);
    end
  end

  assign stall      = (state != IDLE);
  assign done       = (state == DONE);
  assign err        = done & err_q;
  assign read       = (state == ACCESS) & ~we_q;
  assign write      = (state == ACCESS) & we_q;
  assign byteenable = (state == ACCESS) ? lane_enables(size_q, addr_q[1:0]) : 4'b0000;
  assign address    = {addr_q[31:2], 2'b00};
  assign writedata  = replicate(size_q, wdata_q);

endmodule

// File: tb/tb_avalon_mem_sequencer.sv
// Self-checking bench for avalon_mem_sequencer with MAX_WAIT = 4.
module tb_avalon_mem_sequencer;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset, req, we, sign_ext, waitrequest;
  logic [31:0] addr, wdata, readdata;
  logic [1:0]  size;
  logic        stall, done, err, read, write;
  logic [31:0] rdata, address, writedata;
  logic [3:0]  byteenable;

  always #5 clk = ~clk;

  avalon_mem_sequencer #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .size(size),
    .sign_ext(sign_ext), .wdata(wdata), .stall(stall), .done(done), .err(err),
    .rdata(rdata), .address(address), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .waitrequest(waitrequest),
    .readdata(readdata)
  );

  int checks = 0;
  int passes = 0;
  logic [31:0] model_rdata;

  // Observations gathered by run_access.
  int          lat, n_rd, n_wr;
  logic        unstable, o_err, o_done_next, o_stall_after, o_stall_pre;
  logic [31:0] o_addr, o_wd, o_rdata;
  logic [3:0]  o_be;

  // Reference model, derived from the lane and extension rules.
  function automatic logic is_mis(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'd1 && (a % 2) != 0) || (sz >= 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [1:0] sz);
    int lane;
    lane = a % 4;
    if (sz == 2'd0) return 4'(1 << lane);
    if (sz == 2'd1) return (lane >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [31:0] d, input logic [1:0] sz);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_ext(input logic [31:0] rd, input logic [31:0] a,
                                          input logic [1:0] sz, input logic sx);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (sx && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2'd1) begin
      v = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      if (sx && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Drives one request, then scrambles the live inputs so that only the
  // registered copy can explain the bus. Records what the DUT did.
  task automatic run_access(input logic w, input logic [31:0] a, input logic [1:0] sz,
                            input logic sx, input logic [31:0] wd, input logic [31:0] rd,
                            input int nwait);
    int j;
    lat = -1; n_rd = 0; n_wr = 0; unstable = 1'b0; o_err = 1'b0;
    o_addr = 32'h0; o_wd = 32'h0; o_be = 4'h0; o_rdata = 32'h0;
    req = 1'b1; we = w; addr = a; size = sz; sign_ext = sx; wdata = wd;
    readdata = rd; waitrequest = (nwait > 0);
    o_stall_pre = stall;
    @(posedge clk); #1;
    req = 1'b0; addr = $urandom; wdata = $urandom; size = 2'($urandom);
    we = 1'($urandom); sign_ext = 1'($urandom);
    j = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        lat = k; o_err = err; o_rdata = rdata;
        break;
      end
      if (read || write) begin
        if (j == 0) begin
          o_addr = address; o_be = byteenable; o_wd = writedata;
        end else if (address !== o_addr || byteenable !== o_be || writedata !== o_wd) begin
          unstable = 1'b1;
        end
        n_rd += int'(read); n_wr += int'(write);
        waitrequest = (j < nwait);
        j++;
      end
      @(posedge clk); #1;
    end
    waitrequest = 1'($urandom);
    @(posedge clk); #1;
    o_done_next = done; o_stall_after = stall;
    waitrequest = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; size = 2'd0; sign_ext = 1'b0;
    wdata = 32'h0; waitrequest = 1'b0; readdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({stall, done, err, read, write} !== 5'b0)
      $display("FAIL reset_ctrl got %b want 00000", {stall, done, err, read, write});
    else passes++;
    checks++;
    if (byteenable !== 4'h0 || address !== 32'h0 || writedata !== 32'h0 || rdata !== 32'h0)
      $display("FAIL reset_data be=%h addr=%h wd=%h rdata=%h want all 0", byteenable, address, writedata, rdata);
    else passes++;
    reset = 1'b0;
    model_rdata = 32'h0;
  endtask

  task automatic test_word_read();
    run_access(1'b0, 32'h0000_1004, 2'd2, 1'b0, 32'h0, 32'hDEAD_BEEF, 0);
    model_rdata = 32'hDEAD_BEEF;
    checks++;
    if (n_rd !== 1 || n_wr !== 0) $display("FAIL wr_strobes rd=%0d wr=%0d want 1/0", n_rd, n_wr);
    else passes++;
    checks++;
    if (o_addr !== 32'h1004 || o_be !== 4'hF) $display("FAIL wr_bus addr=%h be=%h want 00001004/f", o_addr, o_be);
    else passes++;
    checks++;
    if (lat !== 1 || o_rdata !== 32'hDEAD_BEEF || o_err !== 1'b0)
      $display("FAIL wr_done lat=%0d rdata=%h err=%b want 1/deadbeef/0", lat, o_rdata, o_err);
    else passes++;
    checks++;
    if (o_stall_pre !== 1'b0 || o_done_next !== 1'b0 || o_stall_after !== 1'b0)
      $display("FAIL wr_stall pre=%b done_next=%b after=%b want 0/0/0", o_stall_pre, o_done_next, o_stall_after);
    else passes++;
  endtask

  task automatic test_byte_read();
    run_access(1'b0, 32'h0000_2003, 2'd0, 1'b1, 32'h0, 32'h80FF_1234, 0);
    checks++;
    if (o_be !== 4'b1000 || o_addr !== 32'h2000 || o_rdata !== 32'hFFFF_FF80)
      $display("FAIL byte_signed be=%b addr=%h rdata=%h want 1000/00002000/ffffff80", o_be, o_addr, o_rdata);
    else passes++;
    run_access(1'b0, 32'h0000_2003, 2'd0, 1'b0, 32'h0, 32'h80FF_1234, 0);
    model_rdata = 32'h0000_0080;
    checks++;
    if (o_rdata !== 32'h0000_0080 || lat !== 1) $display("FAIL byte_unsigned rdata=%h lat=%0d want 00000080/1", o_rdata, lat);
    else passes++;
  endtask

  task automatic test_half_write();
    run_access(1'b1, 32'h0000_3002, 2'd1, 1'b0, 32'h0000_ABCD, 32'h1111_2222, 3);
    checks++;
    if (n_wr !== 4 || n_rd !== 0 || unstable !== 1'b0)
      $display("FAIL hw_strobes wr=%0d rd=%0d unstable=%b want 4/0/0", n_wr, n_rd, unstable);
    else passes++;
    checks++;
    if (o_addr !== 32'h3000 || o_be !== 4'b1100 || o_wd !== 32'hABCD_ABCD)
      $display("FAIL hw_bus addr=%h be=%b wd=%h want 00003000/1100/abcdabcd", o_addr, o_be, o_wd);
    else passes++;
    checks++;
    if (lat !== 4 || o_err !== 1'b0 || o_rdata !== model_rdata)
      $display("FAIL hw_done lat=%0d err=%b rdata=%h want 4/0/%h", lat, o_err, o_rdata, model_rdata);
    else passes++;
  endtask

  task automatic test_misaligned();
    run_access(1'b0, 32'h0000_4001, 2'd2, 1'b0, 32'h0, 32'h5555_AAAA, 0);
    checks++;
    if (n_rd + n_wr !== 0 || lat !== 0 || o_err !== 1'b1)
      $display("FAIL misalign strobes=%0d lat=%0d err=%b want 0/0/1", n_rd + n_wr, lat, o_err);
    else passes++;
    checks++;
    if (o_rdata !== model_rdata || o_done_next !== 1'b0)
      $display("FAIL misalign_rdata rdata=%h done_next=%b want %h/0", o_rdata, o_done_next, model_rdata);
    else passes++;
  endtask

  task automatic test_watchdog();
    run_access(1'b0, 32'h0000_6000, 2'd2, 1'b0, 32'h0, 32'h7777_7777, 1000);
    checks++;
    if (n_rd !== MAX_WAIT || lat !== MAX_WAIT || o_err !== 1'b1)
      $display("FAIL watchdog rd=%0d lat=%0d err=%b want %0d/%0d/1", n_rd, lat, o_err, MAX_WAIT, MAX_WAIT);
    else passes++;
    checks++;
    if (o_rdata !== model_rdata || o_stall_after !== 1'b0)
      $display("FAIL watchdog_after rdata=%h stall=%b want %h/0", o_rdata, o_stall_after, model_rdata);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [8:0] rd_vec, dn_vec;
    logic [31:0] d;
    d = $urandom;
    rd_vec = '0; dn_vec = '0;
    req = 1'b1; we = 1'b0; addr = 32'h0000_0100; size = 2'd2; sign_ext = 1'b0;
    waitrequest = 1'b0; readdata = d;
    @(posedge clk); #1;
    for (int k = 0; k < 9; k++) begin
      rd_vec[k] = read; dn_vec[k] = done;
      if (k == 7) req = 1'b0;
      @(posedge clk); #1;
    end
    model_rdata = d;
    checks++;
    if (rd_vec !== 9'b001001001 || dn_vec !== 9'b010010010)
      $display("FAIL b2b read=%b done=%b want 001001001/010010010", rd_vec, dn_vec);
    else passes++;
    checks++;
    if (rdata !== d || stall !== 1'b0) $display("FAIL b2b_rdata rdata=%h stall=%b want %h/0", rdata, stall, d);
    else passes++;
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] d;
    req = 1'b1; we = 1'b0; addr = 32'h0000_7000; size = 2'd2; sign_ext = 1'b0;
    waitrequest = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    checks++;
    if (read !== 1'b1 || rdata === 32'h0) $display("FAIL rst_pre read=%b rdata=%h want 1/nonzero", read, rdata);
    else passes++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (read !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0 || address !== 32'h0 || byteenable !== 4'h0)
      $display("FAIL rst_async read=%b stall=%b rdata=%h addr=%h be=%h want 0/0/0/0/0", read, stall, rdata, address, byteenable);
    else passes++;
    @(posedge clk); #1;
    reset = 1'b0; waitrequest = 1'b0;
    model_rdata = 32'h0;
    d = $urandom;
    run_access(1'b0, 32'h0000_8008, 2'd2, 1'b0, 32'h0, d, 0);
    model_rdata = d;
    checks++;
    if (lat !== 1 || o_rdata !== d || o_err !== 1'b0)
      $display("FAIL rst_recover lat=%0d rdata=%h err=%b want 1/%h/0", lat, o_rdata, o_err, d);
    else passes++;
  endtask

  task automatic test_random();
    logic        w, sx, mis, tmo;
    logic [31:0] a, wd, rd;
    logic [1:0]  sz;
    int          nw, e_lat, e_strb;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom); sx = 1'($urandom); sz = 2'($urandom);
      a = $urandom; wd = $urandom; rd = $urandom;
      if ($urandom_range(0, 2) != 0) a = a & ~32'h3 | (a & ((sz == 0) ? 32'h3 : (sz == 1) ? 32'h2 : 32'h0));
      nw = $urandom_range(0, MAX_WAIT + 1);
      mis = is_mis(a, sz);
      tmo = !mis && (nw >= MAX_WAIT);
      e_strb = mis ? 0 : (tmo ? MAX_WAIT : nw + 1);
      e_lat = e_strb;
      run_access(w, a, sz, sx, wd, rd, nw);
      if (!mis && !tmo && !w) model_rdata = exp_ext(rd, a, sz, sx);
      checks++;
      if (lat !== e_lat || o_err !== (mis || tmo))
        $display("FAIL rnd_done[%0d] lat=%0d err=%b want %0d/%b", i, lat, o_err, e_lat, mis || tmo);
      else passes++;
      checks++;
      if (n_rd !== (w ? 0 : e_strb) || n_wr !== (w ? e_strb : 0))
        $display("FAIL rnd_strobe[%0d] rd=%0d wr=%0d want %0d/%0d", i, n_rd, n_wr, w ? 0 : e_strb, w ? e_strb : 0);
      else passes++;
      checks++;
      if (o_rdata !== model_rdata || o_done_next !== 1'b0 || o_stall_after !== 1'b0)
        $display("FAIL rnd_rdata[%0d] rdata=%h done_next=%b stall=%b want %h/0/0", i, o_rdata, o_done_next, o_stall_after, model_rdata);
      else passes++;
      if (e_strb > 0) begin
        checks++;
        if (o_addr !== (a & ~32'h3) || o_be !== exp_be(a, sz) || o_wd !== exp_wd(wd, sz) || unstable !== 1'b0)
          $display("FAIL rnd_bus[%0d] addr=%h be=%b wd=%h unstable=%b want %h/%b/%h/0", i, o_addr, o_be, o_wd,
                   unstable, a & ~32'h3, exp_be(a, sz), exp_wd(wd, sz));
        else passes++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_read();
    test_half_write();
    test_misaligned();
    test_watchdog();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
